// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: write strobe/op/address/data, read addresses,
// registered read data and sticky overflow flag. master drives, slave is the bank.
interface reg_bank_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] DBUS;
  logic             Wn;
  logic [1:0]       Op;
  logic [AW-1:0]    WAddr;
  logic [AW-1:0]    RAddrA;
  logic [AW-1:0]    RAddrB;
  logic [WIDTH-1:0] QA;
  logic [WIDTH-1:0] QB;
  logic             Ovf;

  modport master (
    output DBUS, Wn, Op, WAddr, RAddrA, RAddrB,
    input  QA, QB, Ovf
  );

  modport slave (
    input  DBUS, Wn, Op, WAddr, RAddrA, RAddrB,
    output QA, QB, Ovf
  );
endinterface

// File: rtl/reg_bank.sv
// NREGS x WIDTH register bank: one write port (LOAD/MOVE/INC/CLR, Wn active low),
// two write-first registered read ports QA/QB, sticky INC-wrap flag Ovf.
module reg_bank #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input logic      Clock,
  input logic      Resetn,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] nxt  [NREGS];

  logic             wa_ok;
  logic             ra_ok;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] src;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             ovf_set;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;

  assign wa_ok = {1'b0, bus.WAddr} < NR;
  assign ra_ok = {1'b0, bus.RAddrA} < NR;

  always_comb begin
    cur = '0;
    src = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.WAddr == AW'(i))  cur = regs[i];
      if (bus.RAddrA == AW'(i)) src = regs[i];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    ovf_set = 1'b0;
    if (!bus.Wn && wa_ok) begin
      unique case (1'b1)
        bus.Op == OP_LOAD: begin
          wr_en   = 1'b1;
          wr_data = bus.DBUS;
        end
        bus.Op == OP_MOVE: begin
          // invalid source suppresses the write entirely
          wr_en   = ra_ok;
          wr_data = src;
        end
        bus.Op == OP_INC: begin
          wr_en   = 1'b1;
          wr_data = cur + WIDTH'(1);
          ovf_set = &cur;
        end
        bus.Op == OP_CLR: begin
          wr_en   = 1'b1;
          wr_data = '0;
        end
        default: ;
      endcase
    end
  end

  // post-write view feeds the read ports (write-first)
  always_comb begin
    rda = '0;
    rdb = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en && bus.WAddr == AW'(i)) nxt[i] = wr_data;
      else                              nxt[i] = regs[i];
    end
    for (int i = 0; i < NREGS; i++) begin
      if (bus.RAddrA == AW'(i)) rda = nxt[i];
      if (bus.RAddrB == AW'(i)) rdb = nxt[i];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bus.QA  <= '0;
      bus.QB  <= '0;
      bus.Ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs[i] <= nxt[i];
      bus.QA <= rda;
      bus.QB <= rdb;
      if (ovf_set) bus.Ovf <= 1'b1;
    end
  end
endmodule
